// File: rtl/time_entry_loader.sv
// rtl/time_entry_loader.sv - keypad MM:SS entry buffer and parallel loader for the timer counter chain
module time_entry_loader #(
  parameter int MAX_DIGITS = 3,
  parameter int TENS_MAX   = 5
) (
  input  logic       clock,
  input  logic       clrn,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       clear_key,
  input  logic       start_key,
  input  logic       timer_done,
  output logic       loadn,
  output logic [3:0] min_data,
  output logic [3:0] tens_data,
  output logic [3:0] ones_data,
  output logic [1:0] digit_cnt,
  output logic       busy,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, ENTRY, LOAD, RUN} state_t;

  localparam logic [1:0] MAX_CNT  = 2'(MAX_DIGITS);
  localparam logic [3:0] TENS_LIM = 4'(TENS_MAX);

  state_t     state, state_n;
  logic [3:0] min_q, tens_q, ones_q;
  logic [3:0] min_n, tens_n, ones_n;
  logic [1:0] cnt_q, cnt_n;
  logic       err_q, err_n;
  logic       loadn_q;
  logic       legal_key;

  assign legal_key = key_valid && (key_digit <= 4'd9);

  always_comb begin
    state_n = state;
    min_n   = min_q;
    tens_n  = tens_q;
    ones_n  = ones_q;
    cnt_n   = cnt_q;
    err_n   = err_q;
    // Strobe priority is start > clear > key; a lower strobe in the same cycle is dropped.
    case (state)
      IDLE: begin
        if (start_key) begin
          state_n = IDLE;
        end else if (clear_key) begin
          err_n = 1'b0;
        end else if (legal_key) begin
          min_n   = tens_q;
          tens_n  = ones_q;
          ones_n  = key_digit;
          cnt_n   = 2'd1;
          err_n   = 1'b0;
          state_n = ENTRY;
        end
      end
      ENTRY: begin
        if (start_key) begin
          if (tens_q > TENS_LIM)
            err_n = 1'b1;
          else if ((min_q | tens_q | ones_q) != 4'd0)
            state_n = LOAD;
        end else if (clear_key) begin
          min_n   = 4'd0;
          tens_n  = 4'd0;
          ones_n  = 4'd0;
          cnt_n   = 2'd0;
          err_n   = 1'b0;
          state_n = IDLE;
        end else if (legal_key && (cnt_q < MAX_CNT)) begin
          min_n  = tens_q;
          tens_n = ones_q;
          ones_n = key_digit;
          cnt_n  = cnt_q + 2'd1;
        end
      end
      LOAD: state_n = RUN;
      RUN: begin
        if (timer_done) begin
          min_n   = 4'd0;
          tens_n  = 4'd0;
          ones_n  = 4'd0;
          cnt_n   = 2'd0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // loadn is registered from the next state so it is glitch-free and low for exactly the LOAD cycle.
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      state   <= IDLE;
      min_q   <= 4'd0;
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
      cnt_q   <= 2'd0;
      err_q   <= 1'b0;
      loadn_q <= 1'b1;
    end else begin
      state   <= state_n;
      min_q   <= min_n;
      tens_q  <= tens_n;
      ones_q  <= ones_n;
      cnt_q   <= cnt_n;
      err_q   <= err_n;
      loadn_q <= (state_n != LOAD);
    end
  end

  assign loadn     = loadn_q;
  assign min_data  = min_q;
  assign tens_data = tens_q;
  assign ones_data = ones_q;
  assign digit_cnt = cnt_q;
  assign err       = err_q;
  assign busy      = (state == LOAD) || (state == RUN);

endmodule

// File: doc/time_entry_loader.md
Name: time_entry_loader

Overview:
Keypad-side writer for the cooking-timer counter chain. It collects BCD digits typed by the user into a 3-digit MM:SS buffer (minutes, seconds-tens, seconds-ones) and validates the entry. On start it drives the digits onto the counters' parallel data buses with a one-cycle active-low load strobe. It then locks out entry until the counter chain reports completion. It sits between the keypad encoder and the minutes/seconds-tens/seconds-ones down-counters.

Parameters:
MAX_DIGITS, 3, number of digits accepted per entry (digits beyond this are ignored)
TENS_MAX, 5, largest legal seconds-tens value (mod-6 counter range 0..5)

Ports:
clock  input  1  system clock, rising edge
clrn  input  1  asynchronous active-low reset
key_valid  input  1  one-cycle strobe: key_digit holds a new keypress
key_digit  input  4  BCD digit 0..9; 10..15 are illegal
clear_key  input  1  one-cycle strobe: discard the current entry
start_key  input  1  one-cycle strobe: commit the entry and load the counters
timer_done  input  1  level from the counter chain: all counters at zero and terminal count reached
loadn  output  1  active-low parallel-load strobe to all three counters
min_data  output  4  minutes digit to the minutes counter data input
tens_data  output  4  seconds-tens digit to the mod-6 counter data input
ones_data  output  4  seconds-ones digit to the mod-10 counter data input
digit_cnt  output  2  number of digits currently buffered (0..MAX_DIGITS)
busy  output  1  high in LOAD and RUN (entry locked)
err  output  1  sticky: last start attempt rejected (seconds-tens > TENS_MAX)

Behaviour:
- Reset is clrn=0, asynchronous. Resulting state: IDLE, loadn=1, min/tens/ones_data=0, digit_cnt=0, busy=0, err=0. Reset asserted during LOAD releases loadn to 1 immediately, without waiting for a clock edge.
- The FSM has 4 states: IDLE, ENTRY, LOAD, RUN. All transitions occur on the rising clock edge.
- IDLE, key_valid with key_digit<=9:
  - shift the digit in: min<=tens, tens<=ones, ones<=key_digit
  - digit_cnt<=1, err<=0
  - go to ENTRY
- ENTRY, key_valid with a legal digit and digit_cnt<MAX_DIGITS: same shift, digit_cnt+1.
- ENTRY, digit_cnt==MAX_DIGITS: further digits are ignored; buffer and count unchanged.
- Any state, key_digit>9: the keypress is ignored entirely.
- Leading zeros count as digits. Typing "0","0","5" gives 0:05 with digit_cnt=3.
- ENTRY, clear_key: buffer<=0, digit_cnt<=0, err<=0, go to IDLE. In IDLE, clear_key only clears err.
- ENTRY, start_key:
  - tens_data>TENS_MAX: err<=1, stay in ENTRY, buffer kept.
  - all three digits zero: ignored, stay in ENTRY.
  - otherwise: go to LOAD.
- IDLE, start_key: ignored (no load of 0:00).
- Simultaneous strobes in the same cycle have this priority: start_key > clear_key > key_valid. Lower-priority strobes in that cycle are dropped.
- LOAD lasts exactly one cycle:
  - loadn=0 (registered output, low for exactly one clock period)
  - data outputs hold the buffer value and stay stable from the cycle before loadn falls until after it rises
  - next state is RUN
- RUN:
  - busy=1; data outputs keep the loaded value
  - key_valid, clear_key and start_key are all ignored
  - timer_done=1 (sampled at the clock edge): buffer<=0, digit_cnt<=0, go to IDLE
- timer_done is ignored outside RUN. If timer_done is already high on the first RUN cycle, the FSM leaves RUN after that one cycle.
- loadn is 1 in every state except LOAD. busy=1 exactly in LOAD and RUN. digit_cnt saturates at MAX_DIGITS and never wraps.

Test Plan:
- Reset sequence:
  - clrn=0 mid-LOAD -> loadn=1 asynchronously, all data=0, digit_cnt=0, busy=0
  - after release: keys "1","3","0" -> min=1, tens=3, ones=0, digit_cnt=3
- Entry, start and run:
  - keys "2","4" -> ones=4, tens=2, min=0
  - start_key -> next cycle loadn=0 for exactly 1 cycle with data 0/2/4, busy=1
  - timer_done=1 -> IDLE, data=0, busy=0
- Overflow and illegal digits:
  - keys "1","2","3","7" -> 4th key ignored, buffer 1/2/3
  - key_digit=12 in ENTRY -> no change
- Seconds-tens check:
  - keys "7","5" (tens=7, ones=5) then start -> err=1, loadn stays 1, state ENTRY
  - clear_key -> err=0, digit_cnt=0, state IDLE
- Lockout in RUN: key_valid, clear_key and start_key pulsed during RUN -> buffer, loadn and state unchanged.
- Strobe collisions:
  - start_key and key_valid("9") in the same cycle with buffer 0/4/5 -> load of 0/4/5; 9 discarded
  - start_key in IDLE -> no loadn pulse
